serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor built around a half-subtractor cell plus a registered borrow flip-flop; the inverse arithmetic of the existing half-adder datapath.
- Accepts operands A and B on a start strobe and computes A-B LSB-first, one bit per clock.
- Returns the difference and the final borrow with a one-cycle done pulse.
- Sits as a low-area arithmetic slave beside the adder blocks under a simple start/busy/done handshake.

Parameters:
WIDTH  8  operand and result width in bits, legal range 2..32

Ports:
clk     input   1      system clock, rising-edge
rst     input   1      reset, asynchronous, active-high
start   input   1      request; sampled only in IDLE
a       input   WIDTH  minuend; captured on the accepted start
b       input   WIDTH  subtrahend; captured on the accepted start
busy    output  1      high while an operation is in progress (SHIFT state)
done    output  1      one-cycle pulse: result valid
diff    output  WIDTH  A-B modulo 2^WIDTH; registered
borrow  output  1      1 when A<B unsigned; registered

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst is asynchronous, active-high.
  - While rst=1, state=IDLE, busy=0, done=0, diff=0, borrow=0, all internal shift registers, the borrow flop and the counter are 0.
- States:
  - IDLE
  - SHIFT: busy=1
  - DONE: done=1 for exactly one cycle
- IDLE:
  - If start=1 at rising edge E0: load shift regs sa<=a, sb<=b; borrow flop br<=0; counter cnt<=0; go to SHIFT.
  - If start=0, stay in IDLE.
- SHIFT, each edge:
  - Difference bit d = sa[0]^sb[0]^br.
  - New borrow br <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - Result shift reg sr <= {d, sr[WIDTH-1:1]}.
  - sa and sb shift right by 1; cnt increments.
  - On the edge where cnt reaches WIDTH-1 (the WIDTH-th shift edge, E_WIDTH):
    - diff <= final sr value, including this cycle's d.
    - borrow <= new br.
    - Go to DONE.
- DONE:
  - done=1 for one cycle; next edge goes to IDLE.
  - start during DONE is ignored.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH+1 cycles after the start cycle. Minimum start-to-start interval is WIDTH+2 cycles.
- busy is 1 in SHIFT only. It is 0 in IDLE and DONE.
- Output hold rules:
  - diff and borrow change only at the completion edge and hold until the next completion or reset.
  - Intermediate shift values are never visible on diff.
- start while busy or in DONE: ignored, no queuing, current operation unaffected.
- a and b may change freely after the accepted start; only the captured values are used.
- Arithmetic: unsigned. diff = (a - b) mod 2^WIDTH; borrow = (a < b).
- Reset mid-operation: immediate abort to IDLE, outputs zeroed, no done pulse; the next start begins a fresh operation.
- start held high continuously: a new operation is accepted on each return to IDLE (every WIDTH+2 cycles).

Test Plan:
1. rst pulse while mid-SHIFT, after 3 shift cycles (start a=8'd200, b=8'd1 before it) -> busy, done, diff and borrow go 0 immediately; no done pulse follows. A subsequent start a=8'd1, b=8'd1 -> diff=0, borrow=0.
2. WIDTH=8, start with a=8'd100, b=8'd37 -> done high exactly 9 cycles after the start cycle; diff=8'd63, borrow=0; busy high for exactly 8 cycles.
3. a=8'd5, b=8'd9 -> diff=8'd252, borrow=1. a=8'd0, b=8'd1 -> diff=8'd255, borrow=1.
4. Boundary operands:
   - a=8'd255, b=8'd255 -> diff=0, borrow=0.
   - a=8'd0, b=8'd0 -> diff=0, borrow=0.
   - a=8'd255, b=8'd0 -> diff=8'd255, borrow=0.
5. Start a=8'd50, b=8'd20; pulse start with a=8'd1, b=8'd2 during SHIFT and again during DONE -> exactly one done pulse, diff=8'd30, borrow=0. Outputs hold 30/0 until the next accepted start completes.
6. start held at 1 for 40 cycles with a=8'd10, b=8'd3 -> done pulses every 10 cycles, each with diff=8'd7, borrow=0. Repeat the directed and 200 random vectors at WIDTH=4 against a reference (a-b) model.

Source files
------------

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// using a half-subtractor cell with a registered borrow flop. Sits beside the
// bit-serial adder blocks under a start/busy/done handshake.
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous, active-high reset
//   start   in   1      operation request, honoured only when idle
//   a       in   WIDTH  minuend, captured on the accepted start
//   b       in   WIDTH  subtrahend, captured on the accepted start
//   busy    out  1      high while bits are being shifted
//   done    out  1      one-cycle pulse, diff/borrow freshly valid
//   diff    out  WIDTH  (a - b) mod 2^WIDTH, registered, held between results
//   borrow  out  1      1 when a < b (unsigned), registered
//
// Timing: start sampled at edge E0, WIDTH shift edges follow, done is high for
// the cycle after the last shift edge, and the block is back in IDLE one edge
// later. Back-to-back operations therefore start every WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Counter only has to reach WIDTH-1; keep it at least one bit wide.
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;        // minuend shift register
  logic [WIDTH-1:0] sb_q;        // subtrahend shift register
  logic [WIDTH-1:0] sr_q;        // result shift register, filled from the MSB end
  logic [WIDTH-1:0] sr_d;
  logic             br_q;        // borrow carried between bit positions
  logic             br_d;
  logic             d_bit;
  logic [CNT_W-1:0] cnt_q;
  logic             last_shift;

  // Half-subtractor cell plus borrow-in. The result register fills from the
  // top so that after WIDTH shifts bit 0 of the difference sits at sr[0].
  // NOTE: every signal in this block is assigned on every pass, so no latch
  // can be inferred; any later conditional logic here needs a default first.
  always_comb begin
    d_bit      = sa_q[0] ^ sb_q[0] ^ br_q;
    br_d       = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    sr_d       = {d_bit, sr_q[WIDTH-1:1]};
    last_shift = (cnt_q == CNT_LAST);
  end

  // Single-process FSM; busy and done are registered alongside the state so
  // they are glitch-free and change exactly on state transitions.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          sr_q  <= sr_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CNT_ONE;
          // Publish from sr_d/br_d so the last bit computed this cycle is
          // included; diff/borrow are never written mid-operation.
          if (last_shift) begin
            diff    <= sr_d;
            borrow  <= br_d;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          // start is deliberately not looked at here.
          done    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WIDTH=8 instance
  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;

  // WIDTH=4 instance
  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4, borrow4;
  logic [3:0] diff4;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] last_diff8 = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation with hand-computed expected results.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb, input string tag);
    int edges;
    int busy_cnt;
    bit seen;
    start8 = 1'b1; a8 = av; b8 = bv;
    tick();                               // edge E0
    start8 = 1'b0; a8 = ~av; b8 = ~bv;    // captured values must be used
    check({tag, " diff_hold"}, diff8, last_diff8);
    edges = 0; busy_cnt = 0; seen = 0;
    while (!seen && edges < 20) begin
      if (done8) seen = 1;
      else begin
        if (busy8) busy_cnt++;
        tick();
        edges++;
      end
    end
    check({tag, " latency"}, edges, 8);
    check({tag, " busy_cycles"}, busy_cnt, 8);
    check({tag, " diff"}, diff8, ed);
    check({tag, " borrow"}, borrow8, eb);
    check({tag, " busy_in_done"}, busy8, 0);
    tick();
    check({tag, " done_pulse_len"}, done8, 0);
    last_diff8 = ed;
  endtask

  // One WIDTH=4 operation; expected values supplied by caller.
  task automatic op4(input logic [3:0] av, input logic [3:0] bv,
                     input logic [3:0] ed, input logic eb, input string tag);
    int edges;
    bit seen;
    start4 = 1'b1; a4 = av; b4 = bv;
    tick();
    start4 = 1'b0; a4 = ~av; b4 = ~bv;
    edges = 0; seen = 0;
    while (!seen && edges < 12) begin
      if (done4) seen = 1;
      else begin
        tick();
        edges++;
      end
    end
    check({tag, " latency"}, edges, 4);
    check({tag, " diff"}, diff4, ed);
    check({tag, " borrow"}, borrow4, eb);
    tick();
    check({tag, " done_pulse_len"}, done4, 0);
  endtask

  initial begin
    int pulses;
    int prev;
    logic [3:0] ra, rb;
    logic [4:0] rdiff;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    #12;
    check("rst busy",   busy8,   0);
    check("rst done",   done8,   0);
    check("rst diff",   diff8,   0);
    check("rst borrow", borrow8, 0);
    check("rst diff4",  diff4,   0);
    #2 rst = 1'b0;
    tick();

    // Basic operation with latency and busy-length checks
    op8(8'd100, 8'd37, 8'd63, 1'b0, "t2 100-37");

    // Borrow cases
    op8(8'd5, 8'd9, 8'd252, 1'b1, "t3 5-9");
    op8(8'd0, 8'd1, 8'd255, 1'b1, "t3 0-1");

    // Reset in the middle of SHIFT (diff currently 255, borrow 1)
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("t1 rst busy",   busy8,   0);
    check("t1 rst done",   done8,   0);
    check("t1 rst diff",   diff8,   0);
    check("t1 rst borrow", borrow8, 0);
    #2 rst = 1'b0;
    last_diff8 = 8'd0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) pulses++;
    end
    check("t1 no done after abort", pulses, 0);
    op8(8'd1, 8'd1, 8'd0, 1'b0, "t1 1-1");

    // Boundary operands
    op8(8'd255, 8'd255, 8'd0,   1'b0, "t4 255-255");
    op8(8'd0,   8'd0,   8'd0,   1'b0, "t4 0-0");
    op8(8'd255, 8'd0,   8'd255, 1'b0, "t4 255-0");

    // start pulses during SHIFT and DONE are ignored
    start8 = 1'b1; a8 = 8'd50; b8 = 8'd20;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd2;
    tick();
    start8 = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        pulses++;
        if (pulses == 1) begin
          check("t5 diff", diff8, 30);
          check("t5 borrow", borrow8, 0);
          start8 = 1'b1;                  // sampled while in DONE
        end
      end
      tick();
      start8 = 1'b0;
    end
    check("t5 one done pulse", pulses, 1);
    check("t5 diff hold", diff8, 30);
    check("t5 borrow hold", borrow8, 0);
    check("t5 idle busy", busy8, 0);
    last_diff8 = 8'd30;

    // start held high: new operation every WIDTH+2 cycles
    start8 = 1'b1; a8 = 8'd10; b8 = 8'd3;
    pulses = 0; prev = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done8) begin
        pulses++;
        check("t6 diff", diff8, 7);
        check("t6 borrow", borrow8, 0);
        if (prev >= 0) check("t6 interval", i - prev, 10);
        prev = i;
      end
    end
    start8 = 1'b0;
    check("t6 pulse count", pulses, 4);
    tick(); tick(); tick();
    check("t6 idle busy", busy8, 0);

    // WIDTH=4: directed vectors
    op4(4'd5,  4'd9,  4'd12, 1'b1, "w4 5-9");
    op4(4'd0,  4'd1,  4'd15, 1'b1, "w4 0-1");
    op4(4'd15, 4'd15, 4'd0,  1'b0, "w4 15-15");
    op4(4'd0,  4'd0,  4'd0,  1'b0, "w4 0-0");
    op4(4'd15, 4'd0,  4'd15, 1'b0, "w4 15-0");
    op4(4'd10, 4'd3,  4'd7,  1'b0, "w4 10-3");

    // WIDTH=4: random vectors against a plain (a-b) reference
    for (int i = 0; i < 200; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rdiff = {1'b0, ra} - {1'b0, rb};
      op4(ra, rb, rdiff[3:0], (ra < rb), "w4 rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
